seq_alu: RTL and testbench

- Parametrised WIDTH-bit MIPS ALU that succeeds the bit-sliced ripple ALU.
- Adds registered outputs with a valid/ready handshake, NOR/XOR operations, and an iterative unsigned multiply taking WIDTH cycles.
- Sits in the EX stage between operand muxes and the EX/MEM register.
- Reports zero, carry, overflow and set flags per result.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_comb.sv | 54 +++++
 rtl/seq_alu.sv | 125 ++++++++++++
 tb/tb_seq_alu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and control states for the sequential MIPS ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, MUL_BUSY} state_t;
endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic ops plus a shared adder/subtractor driving the flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             set
);
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_ovf;
  logic             w_set;

  // Bit 2 of the op selects subtraction: invert b and inject carry-in.
  assign w_bx            = b ^ {WIDTH{alu_op[2]}};
  assign {w_cout, w_sum} = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, alu_op[2]};
  assign w_cmsb          = a[WIDTH-1] ^ w_bx[WIDTH-1] ^ w_sum[WIDTH-1];
  assign w_ovf           = w_cmsb ^ w_cout;
  assign w_set           = w_ovf ^ w_sum[WIDTH-1];

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    set       = 1'b0;
    case (alu_op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_ADD, OP_SUB: begin
        result    = w_sum;
        carry_out = w_cout;
        overflow  = w_ovf;
        set       = w_set;
      end
      OP_SLT: begin
        result    = {{(WIDTH-1){1'b0}}, w_set};
        carry_out = w_cout;
        overflow  = w_ovf;
        set       = w_set;
      end
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/seq_alu.sv
// EX-stage ALU with registered outputs, valid/ready handshake and a WIDTH-cycle shift-add multiplier.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             set
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_set;

  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_set;
  logic             w_accept;
  logic [WIDTH:0]   w_madd;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .result   (w_res),
    .carry_out(w_carry),
    .overflow (w_ovf),
    .set      (w_set)
  );

  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Partial-product add; its LSB shifts into the multiplier register as the product's low half.
  assign w_madd = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_set       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (alu_op == OP_MUL) begin
              r_mcand     <= a;
              r_mplier    <= b;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= MUL_BUSY;
            end else begin
              r_result    <= w_res;
              r_result_hi <= '0;
              r_zero      <= ~|w_res;
              r_carry     <= w_carry;
              r_ovf       <= w_ovf;
              r_set       <= w_set;
              r_out_valid <= 1'b1;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          r_acc    <= w_madd[WIDTH:1];
          r_mplier <= {w_madd[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_result_hi <= w_madd[WIDTH:1];
            r_result    <= {w_madd[0], r_mplier[WIDTH-1:1]};
            r_zero      <= ~|{w_madd, r_mplier[WIDTH-1:1]};
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_set       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign set       = r_set;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: arithmetic flags, logic streaming, multiply latency, back-pressure, reset abort.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         carry_out;
  logic         overflow;
  logic         set;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .result_hi(result_hi),
    .zero     (zero),
    .carry_out(carry_out),
    .overflow (overflow),
    .set      (set)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single accept edge, then withdraw in_valid.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    alu_op   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; alu_op = 3'b000; a = '0; b = '0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, zero, carry_out, overflow, set} !== 5'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=00000", {out_valid, zero, carry_out, overflow, set});
    end
    checks++;
    if ({result_hi, result} !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {result_hi, result});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    checks++;
    if ({out_valid, result, result_hi} !== {1'b1, 32'h8000_0000, 32'h0}) begin
      failures++; $display("FAIL add_ovf_res got=%b %h %h exp=1 80000000 0", out_valid, result, result_hi);
    end
    checks++;
    if ({zero, carry_out, overflow, set} !== 4'b0010) begin
      failures++; $display("FAIL add_ovf_flags got=%b exp=0010", {zero, carry_out, overflow, set});
    end
    issue(3'b110, 32'd5, 32'd5);
    checks++;
    if ({out_valid, result, zero, carry_out, overflow, set} !== {1'b1, 32'h0, 4'b1100}) begin
      failures++; $display("FAIL sub_eq got=%b %h %b exp=1 0 1100", out_valid, result, {zero, carry_out, overflow, set});
    end
    issue(3'b110, 32'h8000_0000, 32'h1);
    checks++;
    if ({result, zero, carry_out, overflow, set} !== {32'h7FFF_FFFF, 4'b0111}) begin
      failures++; $display("FAIL sub_ovf got=%h %b exp=7fffffff 0111", result, {zero, carry_out, overflow, set});
    end
    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    checks++;
    if ({result, zero, carry_out, overflow, set} !== {32'h1, 4'b0101}) begin
      failures++; $display("FAIL slt_neg got=%h %b exp=00000001 0101", result, {zero, carry_out, overflow, set});
    end
    issue(3'b111, 32'd7, 32'd3);
    checks++;
    if ({result, zero, set} !== {32'h0, 2'b10}) begin
      failures++; $display("FAIL slt_ge got=%h %b exp=0 10", result, {zero, set});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_logic_stream();
    logic [2:0]   ops [4];
    logic [W-1:0] exp [4];
    ops = '{3'b000, 3'b001, 3'b101, 3'b100};
    exp = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F, 32'h0FF0_0FF0};
    out_ready = 1'b1;
    a = 32'hF0F0_F0F0;
    b = 32'hFF00_FF00;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_op = ops[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, result, carry_out, overflow, set} !== {1'b1, exp[i], 3'b000}) begin
        failures++; $display("FAIL stream[%0d] got=%b %h %b exp=1 %h 000", i, out_valid, result, {carry_out, overflow, set}, exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    bit saw_early = 1'b0;
    out_ready = 1'b1;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    alu_op = 3'b000; a = 32'h1234_5678; b = 32'h0; in_valid = 1'b1;
    for (int k = 1; k < W; k++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) saw_early = 1'b1;
      tick();
    end
    checks++;
    if (saw_early || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mul_busy got=%b,%b,%b exp=0,0,0", saw_early, out_valid, in_ready);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, result_hi, result} !== {1'b1, 64'hFFFF_FFFE_0000_0001}) begin
      failures++; $display("FAIL mul_max got=%b %h_%h exp=1 fffffffe_00000001", out_valid, result_hi, result);
    end
    checks++;
    if ({zero, carry_out, overflow, set} !== 4'b0000) begin
      failures++; $display("FAIL mul_flags got=%b exp=0000", {zero, carry_out, overflow, set});
    end
    tick();
    issue(3'b011, 32'h1234_5678, 32'h10);
    repeat (W) tick();
    checks++;
    if ({out_valid, result_hi, result} !== {1'b1, 64'h0000_0001_2345_6780}) begin
      failures++; $display("FAIL mul_shift got=%b %h_%h exp=1 00000001_23456780", out_valid, result_hi, result);
    end
    tick();
    issue(3'b011, 32'h0, 32'hDEAD_BEEF);
    repeat (W) tick();
    checks++;
    if ({out_valid, zero, result_hi, result} !== {2'b11, 64'h0}) begin
      failures++; $display("FAIL mul_zero got=%b %b %h_%h exp=1 1 0", out_valid, zero, result_hi, result);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    bit bad = 1'b0;
    out_ready = 1'b0;
    issue(3'b010, 32'd10, 32'd20);
    alu_op = 3'b110; a = 32'd100; b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd30 || zero !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL bp_hold got=%b %b %h exp=0 1 0000001e", in_ready, out_valid, result);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result, carry_out} !== {1'b1, 32'd99, 1'b1}) begin
      failures++; $display("FAIL bp_next got=%b %h %b exp=1 00000063 1", out_valid, result, carry_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit stale = 1'b0;
    out_ready = 1'b1;
    issue(3'b011, 32'd7, 32'd9);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result_hi, result, zero, carry_out, overflow, set} !== 69'h0) begin
      failures++; $display("FAIL rst_mul_outputs got=%b %h_%h exp=0 0_0", out_valid, result_hi, result);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mul_ready got=%b exp=1", in_ready);
    end
    for (int k = 0; k < W + 8; k++) begin
      if (out_valid !== 1'b0 || result !== 32'h0) stale = 1'b1;
      tick();
    end
    checks++;
    if (stale) begin
      failures++; $display("FAIL rst_mul_stale got=%b %h exp=0 0", out_valid, result);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_stream();
    test_mul();
    test_back_pressure();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
